mat4x4_vec_seq: RTL and testbench
=================================

# mat4x4_vec_seq

Sequencer that computes a 4x4 signed matrix times a 4x1 signed vector by time-sharing one `Mul2vector4x1` dot-product unit. It accepts the vector and then the four matrix rows over a valid/ready input stream, evaluates one row per pass, and emits four 12-bit signed results over a valid/ready output stream. It sits between the host-side load logic and the `Mul2vector4x1` datapath, and is the only driver of that unit's A/B operands.

## Interface
- `DW`, 5: signed element width; matches the dot unit.
- `OW`, 12: signed result width; matches the dot unit.
- `ROWS`, 4: matrix rows per job.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begins a job; sampled only in IDLE.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when valid && ready.
- `in_data`  in  4*DW  packed element 0 in [DW-1:0] ... element 3 in [4*DW-1:3*DW]; signed elements.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  OW  signed dot product of the current row.
- `res_idx`  out  2  row index of `res_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result handshake.

## Operation
- States: IDLE, LOAD_B, LOAD_ROW, CALC, EMIT.
- IDLE: `in_ready`=0. `start`=1 -> LOAD_B, and `row_cnt` is cleared to 0.
- LOAD_B: `in_ready`=1. On handshake, `in_data` is latched into the B register -> LOAD_ROW.
- LOAD_ROW: `in_ready`=1. On handshake, `in_data` is latched into the A register -> CALC.
- CALC: `in_ready`=0. The dot unit output (A reg, B reg) is registered into `res_data`, `res_idx`=`row_cnt`, and `res_valid` is set -> EMIT.
- EMIT: `res_valid`=1, and `res_data`/`res_idx` are held stable. On `res_ready`:
  - if `row_cnt`==ROWS-1: clear `res_valid`, pulse `done`, go to IDLE;
  - else: `row_cnt`+1, go to LOAD_ROW.
- `start` is ignored outside IDLE. `in_valid` is ignored when `in_ready`=0.
- Arithmetic: full signed dot product. Worst case is 4*(-16*-16)=1024 and minimum is -960, so the result always fits OW=12 with no saturation or wrap.
- The dot unit operands come from registers only and are never driven from `in_data` directly.

## Timing
- Reset values: `in_ready`=0, `res_valid`=0, `res_data`=0, `res_idx`=0, `busy`=0, `done`=0, state=IDLE, A/B regs=0.
- Reset mid-job: immediate return to IDLE. The partial job is discarded and no `done` is issued.
- Row handshake in cycle n -> CALC in n+1 -> `res_valid` high from n+2.
- Minimum job length with no stalls: 1 (start) + 1 (B) + 4×3 = 14 cycles, `done` included after.
- `res_valid` stays high until `res_ready`. The result can be accepted in the first EMIT cycle.
- `done` is high for exactly one cycle, the cycle the FSM re-enters IDLE. `start` in that same cycle is accepted.
- `in_ready` and `res_valid` are never high in the same cycle, so no input/output overlap occurs.

## Structure
- Package `mv_pkg`: `DW`, `OW`, `ROWS`, and the state enum `mv_state_t`.
- One sub-module: an instance of the existing `Mul2vector4x1` (A0..A3 from the A reg, B0..B3 from the B reg).
- The FSM, `row_cnt`, operand registers and the result register live in `mat4x4_vec_seq`.

## Test plan
- Basic job: B=[2,-2,2,-5], rows [1,3,-1,-5], [1,3,5,5], [-16,-16,-16,-16], [0,0,0,0] -> results 19, -19, 48, 0 with `res_idx` 0..3, then a single `done` pulse, `busy` low afterwards.
- Extreme: B=[-16,-16,-16,-16], all rows [-16,-16,-16,-16] -> every result 1024, with no wrap. Rows [15,15,15,15] with the same B -> -960.
- Backpressure: hold `res_ready`=0 for 3 cycles on row 1 -> `res_valid` stays high, `res_data` stays stable at -19, and `in_ready` stays 0 throughout.
- Input stalls: drop `in_valid` for 2 cycles between rows -> FSM waits in LOAD_ROW and results are unchanged. Pulse `start` mid-job -> it is ignored.
- Reset mid-job: assert `rst` while in EMIT for row 2 -> all outputs 0 and state IDLE on the same cycle, no `done`. A fresh job afterwards produces correct results.
- Back-to-back: assert `start` in the `done` cycle -> the new job begins with LOAD_B on the next cycle.

Source files
------------

// File: rtl/mv_pkg.sv
`default_nettype none
// ============================================================================
// Package    : mv_pkg
// Purpose    : Shared widths, job geometry and FSM state encoding for the
//              4x4 matrix x 4x1 vector sequencer.
// Contents   : DW       - signed element width
//              OW       - signed dot-product result width
//              ROWS     - matrix rows per job
//              LAST_ROW - row index of the final row in a job
//              mv_state_t - sequencer state enum
// Revision   : 1.0 - initial release
// ============================================================================
package mv_pkg;

  localparam int DW   = 5;
  localparam int OW   = 12;
  localparam int ROWS = 4;

  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_B   = 3'd1,
    LOAD_ROW = 3'd2,
    CALC     = 3'd3,
    EMIT     = 3'd4
  } mv_state_t;

endpackage : mv_pkg
`default_nettype wire

// File: rtl/Mul2vector4x1.sv
`default_nettype none
// ============================================================================
// Module     : Mul2vector4x1
// Purpose    : Combinational signed dot product of two 4-element vectors,
//              Y = A0*B0 + A1*B1 + A2*B2 + A3*B3.
// Ports      : A0..A3 in  DW  signed elements of vector A
//              B0..B3 in  DW  signed elements of vector B
//              Y      out OW  signed dot product
// Revision   : 1.0 - initial release
// ============================================================================
module Mul2vector4x1 #(
  parameter int DW = 5,
  parameter int OW = 12
) (
  input  logic signed [DW-1:0] A0,
  input  logic signed [DW-1:0] A1,
  input  logic signed [DW-1:0] A2,
  input  logic signed [DW-1:0] A3,
  input  logic signed [DW-1:0] B0,
  input  logic signed [DW-1:0] B1,
  input  logic signed [DW-1:0] B2,
  input  logic signed [DW-1:0] B3,
  output logic signed [OW-1:0] Y
);

  // Operands are widened to the result width before multiplying. With
  // DW=5 / OW=12 every product and the full sum fit, so the truncation to
  // OW bits never discards significant bits.
  function automatic logic signed [OW-1:0] sx(input logic signed [DW-1:0] v);
    return {{(OW-DW){v[DW-1]}}, v};
  endfunction

  assign Y = sx(A0) * sx(B0) + sx(A1) * sx(B1)
           + sx(A2) * sx(B2) + sx(A3) * sx(B3);

endmodule : Mul2vector4x1
`default_nettype wire

// File: rtl/mat4x4_vec_seq.sv
`default_nettype none
// ============================================================================
// Module     : mat4x4_vec_seq
// Purpose    : Computes a 4x4 signed matrix times a 4x1 signed vector by
//              time-sharing a single Mul2vector4x1 dot-product unit. The
//              vector arrives first, then the rows one at a time; each row
//              produces one result on the output stream.
// Ports      : clk        in   clock, rising edge
//              rst        in   asynchronous active-high reset
//              start      in   begin a job (sampled only in IDLE)
//              in_valid   in   input beat valid
//              in_ready   out  input beat accepted when valid && ready
//              in_data    in   4 packed signed elements, element 0 in LSBs
//              res_valid  out  result valid
//              res_ready  in   consumer accepts the result
//              res_data   out  signed dot product of the current row
//              res_idx    out  row index of res_data
//              busy       out  high whenever not IDLE
//              done       out  one-cycle pulse on return to IDLE after a job
// Revision   : 1.0 - initial release
// ============================================================================
module mat4x4_vec_seq
  import mv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*DW-1:0] in_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [OW-1:0]   res_data,
  output logic [1:0]      res_idx,
  output logic            busy,
  output logic            done
);

  mv_state_t state;
  mv_state_t next_state;

  logic [1:0]      row_cnt;
  logic [4*DW-1:0] a_reg;
  logic [4*DW-1:0] b_reg;
  logic [OW-1:0]   dot;

  // Datapath strobes decoded by the FSM
  logic load_b;
  logic load_a;
  logic capture;
  logic row_clr;
  logic row_inc;
  logic last_accept;

  // --------------------------------------------------------------------------
  // Dot-product unit: operands come only from the A/B registers
  // --------------------------------------------------------------------------
  Mul2vector4x1 #(
    .DW (DW),
    .OW (OW)
  ) u_dot (
    .A0 (a_reg[0*DW +: DW]),
    .A1 (a_reg[1*DW +: DW]),
    .A2 (a_reg[2*DW +: DW]),
    .A3 (a_reg[3*DW +: DW]),
    .B0 (b_reg[0*DW +: DW]),
    .B1 (b_reg[1*DW +: DW]),
    .B2 (b_reg[2*DW +: DW]),
    .B3 (b_reg[3*DW +: DW]),
    .Y  (dot)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and outputs. in_ready and res_valid are decoded from
  // disjoint states, so they can never be high together, and reset drives
  // them low immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    busy        = (state != IDLE);
    load_b      = 1'b0;
    load_a      = 1'b0;
    capture     = 1'b0;
    row_clr     = 1'b0;
    row_inc     = 1'b0;
    last_accept = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          row_clr    = 1'b1;
          next_state = LOAD_B;
        end
      end

      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_b     = 1'b1;
          next_state = LOAD_ROW;
        end
      end

      LOAD_ROW: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_a     = 1'b1;
          next_state = CALC;
        end
      end

      CALC: begin
        capture    = 1'b1;
        next_state = EMIT;
      end

      EMIT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (row_cnt == LAST_ROW) begin
            last_accept = 1'b1;
            next_state  = IDLE;
          end else begin
            row_inc    = 1'b1;
            next_state = LOAD_ROW;
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand, row counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      res_data <= '0;
      res_idx  <= '0;
      done     <= 1'b0;
    end else begin
      // done is registered so it is high exactly in the first IDLE cycle
      done <= last_accept;

      if (row_clr) begin
        row_cnt <= '0;
      end else if (row_inc) begin
        row_cnt <= row_cnt + 2'd1;
      end

      if (load_b) begin
        b_reg <= in_data;
      end
      if (load_a) begin
        a_reg <= in_data;
      end

      // res_data/res_idx only change in CALC, so they hold through EMIT
      if (capture) begin
        res_data <= dot;
        res_idx  <= row_cnt;
      end
    end
  end

endmodule : mat4x4_vec_seq
`default_nettype wire

// File: tb/tb_mat4x4_vec_seq.sv
`default_nettype none
// ============================================================================
// Module     : tb_mat4x4_vec_seq
// Purpose    : Self-checking bench for mat4x4_vec_seq. Jobs are described as
//              an integer vector and matrix; expected results are plain
//              integer dot products of those arrays.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mat4x4_vec_seq;
  import mv_pkg::*;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            start     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            res_ready = 1'b0;
  logic [4*DW-1:0] in_data   = '0;
  logic            in_ready;
  logic            res_valid;
  logic [OW-1:0]   res_data;
  logic [1:0]      res_idx;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  // Current job: vector jb and matrix jm (row r, element i)
  int jb[4];
  int jm[4][4];

  mat4x4_vec_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // r < 0 packs the vector, otherwise matrix row r
  function automatic logic [4*DW-1:0] pack_row(input int r);
    logic [4*DW-1:0] v;
    int t;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      t = (r < 0) ? jb[i] : jm[r][i];
      v[i*DW +: DW] = t[DW-1:0];
    end
    return v;
  endfunction

  function automatic int ref_dot(input int r);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += jm[r][i] * jb[i];
    return s;
  endfunction

  function automatic int rnd_elem();
    return int'($urandom_range(0, 31)) - 16;
  endfunction

  function automatic int res_int();
    return int'($signed(res_data));
  endfunction

  task automatic send_beat(input logic [4*DW-1:0] d);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready before beat", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 20'($urandom);
  endtask

  task automatic get_result(input int r, input int stall);
    int exp;
    exp = ref_dot(r);
    check("res_valid", int'(res_valid), 1);
    check("res_data", res_int(), exp);
    check("res_idx", int'(res_idx), r);
    check("in_ready in EMIT", int'(in_ready), 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("bp res_valid", int'(res_valid), 1);
      check("bp res_data", res_int(), exp);
      check("bp in_ready", int'(in_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  // Starts in the current cycle, so calling right after a job ends asserts
  // start in the done cycle.
  task automatic run_job(input int stall_row, input int stall_n, input int gap_row);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy in LOAD_B", int'(busy), 1);
    check("in_ready in LOAD_B", int'(in_ready), 1);
    check("done after start", int'(done), 0);
    check("done count", done_cnt, exp_done);
    send_beat(pack_row(-1));
    for (int r = 0; r < 4; r++) begin
      if (r == gap_row) begin
        in_valid = 1'b0;
        start    = 1'b1;
        repeat (2) begin
          @(posedge clk); #1;
          start = 1'b0;
          check("stall in_ready", int'(in_ready), 1);
          check("stall busy", int'(busy), 1);
          check("stall res_valid", int'(res_valid), 0);
        end
      end
      send_beat(pack_row(r));
      check("res_valid in CALC", int'(res_valid), 0);
      @(posedge clk); #1;
      get_result(r, (r == stall_row) ? stall_n : 0);
      if (r < 3) check("done mid job", int'(done), 0);
    end
    check("done pulse", int'(done), 1);
    check("busy after job", int'(busy), 0);
    check("res_valid after job", int'(res_valid), 0);
    exp_done++;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("idle done", int'(done), 0);
      check("idle busy", int'(busy), 0);
    end
  endtask

  task automatic random_job_data();
    for (int i = 0; i < 4; i++) begin
      jb[i] = rnd_elem();
      for (int r = 0; r < 4; r++) jm[r][i] = rnd_elem();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", int'(in_ready), 0);
    check("rst res_valid", int'(res_valid), 0);
    check("rst res_data", res_int(), 0);
    check("rst res_idx", int'(res_idx), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    rst = 1'b0;
    idle_cycles(2);

    // Basic job with backpressure on row 1 and an input gap before row 2
    jb = '{2, -2, 2, -5};
    jm[0] = '{1, 3, -1, -5};
    jm[1] = '{1, 3, 5, 5};
    jm[2] = '{-16, -16, -16, -16};
    jm[3] = '{0, 0, 0, 0};
    run_job(1, 3, 2);
    idle_cycles(2);

    // Extreme values, chained back-to-back from the done cycle
    jb = '{-16, -16, -16, -16};
    for (int r = 0; r < 4; r++) jm[r] = '{-16, -16, -16, -16};
    run_job(-1, 0, -1);
    for (int r = 0; r < 4; r++) jm[r] = '{15, 15, 15, 15};
    run_job(-1, 0, -1);
    idle_cycles(1);

    // Randomized jobs with random stalls and gaps
    for (int j = 0; j < 10; j++) begin
      random_job_data();
      run_job(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);

    // Reset while row 2 is in EMIT
    random_job_data();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_beat(pack_row(-1));
    for (int r = 0; r < 3; r++) begin
      send_beat(pack_row(r));
      @(posedge clk); #1;
      if (r < 2) get_result(r, 0);
    end
    check("pre-reset res_valid", int'(res_valid), 1);
    check("pre-reset res_idx", int'(res_idx), 2);
    rst = 1'b1;
    #1;
    check("mid rst in_ready", int'(in_ready), 0);
    check("mid rst res_valid", int'(res_valid), 0);
    check("mid rst res_data", res_int(), 0);
    check("mid rst res_idx", int'(res_idx), 0);
    check("mid rst busy", int'(busy), 0);
    check("mid rst done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);
    check("no done after reset", done_cnt, exp_done);

    // Fresh job after reset
    random_job_data();
    run_job(0, 1, 1);
    idle_cycles(2);
    check("final done count", done_cnt, exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got simulation still running, expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mat4x4_vec_seq
`default_nettype wire
